// File: rtl/wb_crc_engine_pkg.sv
// wb_crc_pkg: shared register offsets, FSM states and CTRL field positions
// for the Wishbone CRC engine. No ports; imported by the engine RTL.
package wb_crc_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_RESULT = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_RAW    = 3'd3;
    localparam logic [2:0] REG_COUNT  = 3'd4;

    localparam int CTRL_INIT_BIT  = 0;
    localparam int CTRL_RIN_BIT   = 8;
    localparam int CTRL_ROUT_BIT  = 9;
    localparam int CTRL_STATS_BIT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_crc_engine_if.sv
// Wishbone B4 classic bus bundle for the CRC engine.
// Signals: adr/dat_i/sel/we/cti/cyc/stb (master->slave), dat_o/ack (slave->master).
interface wb_crc_engine_if #(
    parameter int AW = 32
) ();
    logic [AW-1:0] wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic [2:0]    wb_cti_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
        output wb_cti_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
        input  wb_cti_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_crc_engine_crc_byte_step.sv
// crc_byte_step: combinational one-byte CRC update, MSB-first shift register form.
// Ports: crc_i (current crc), data_i (input byte), crc_o (updated crc).
module crc_byte_step
    import wb_crc_pkg::*;
#(
    parameter int          CRC_W      = 32,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter bit          REFLECT_IN = 1'b1
) (
    input  logic [CRC_W-1:0] crc_i,
    input  logic [7:0]       data_i,
    output logic [CRC_W-1:0] crc_o
);

    localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];

    logic [7:0]       b;
    logic [CRC_W-1:0] c;
    logic             fb;

    always_comb begin
        b  = REFLECT_IN ? rev8(data_i) : data_i;
        c  = crc_i;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb = c[CRC_W-1] ^ b[7-i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_C : '0);
        end
        crc_o = c;
    end

endmodule

// File: rtl/wb_crc_engine.sv
// wb_crc_engine: Wishbone B4 classic slave computing a generic CRC over
// byte-lane-masked writes, one enabled lane per cycle, ack after the last lane.
// Ports: wb_clk_i, wb_rst_i (async, active low), wb (slave modport of
// wb_crc_engine_if). Optional byte counter: define WB_CRC_STATS_EN.
module wb_crc_engine
    import wb_crc_pkg::*;
#(
    parameter int          CRC_W       = 32,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] INIT        = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
    parameter bit          REFLECT_IN  = 1'b1,
    parameter bit          REFLECT_OUT = 1'b1,
    parameter int          AW          = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_crc_engine_if.slave wb
);

    localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_C  = XOR_OUT[CRC_W-1:0];
`ifdef WB_CRC_STATS_EN
    localparam logic STATS = 1'b1;
`else
    localparam logic STATS = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] crc_step, crc_rev, result;
    logic [31:0]      dbuf_q, dbuf_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      rdata, count_rd;
    logic [3:0]       rem_q, rem_d, rem_next;
    logic [7:0]       lane_byte;
    logic [2:0]       reg_sel;
    logic             req, data_wr;
    logic             unused_ok;

`ifdef WB_CRC_STATS_EN
    logic [31:0] count_q, count_d;
    assign count_rd = count_q;
`else
    assign count_rd = '0;
`endif

    assign reg_sel   = wb.wb_adr_i[4:2];
    assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign data_wr   = wb.wb_we_i & (reg_sel == REG_DATA) & (|wb.wb_sel_i);
    assign unused_ok = ^{wb.wb_cti_i, wb.wb_adr_i};

    // Clearing the lowest set bit walks the lanes from 0 upwards.
    assign rem_next = rem_q & (rem_q - 4'd1);

    always_comb begin
        if (rem_q[0])      lane_byte = dbuf_q[7:0];
        else if (rem_q[1]) lane_byte = dbuf_q[15:8];
        else if (rem_q[2]) lane_byte = dbuf_q[23:16];
        else               lane_byte = dbuf_q[31:24];
    end

    crc_byte_step #(
        .CRC_W      (CRC_W),
        .POLY       (POLY),
        .REFLECT_IN (REFLECT_IN)
    ) u_step (
        .crc_i  (crc_q),
        .data_i (lane_byte),
        .crc_o  (crc_step)
    );

    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < CRC_W; i++) begin
            crc_rev[i] = crc_q[CRC_W-1-i];
        end
        result = (REFLECT_OUT ? crc_rev : crc_q) ^ XOR_C;
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_RESULT: rdata = 32'(result);
            REG_CTRL: begin
                rdata[7:0]            = 8'(CRC_W);
                rdata[CTRL_RIN_BIT]   = REFLECT_IN;
                rdata[CTRL_ROUT_BIT]  = REFLECT_OUT;
                rdata[CTRL_STATS_BIT] = STATS;
            end
            REG_RAW:   rdata = 32'(crc_q);
            REG_COUNT: rdata = count_rd;
            default:   rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        dbuf_d  = dbuf_q;
        rem_d   = rem_q;
        dat_d   = dat_q;
`ifdef WB_CRC_STATS_EN
        count_d = count_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    dat_d = '0;
                    if (data_wr) begin
                        state_d = ST_PROC;
                        dbuf_d  = wb.wb_dat_i;
                        rem_d   = wb.wb_sel_i;
                    end else begin
                        state_d = ST_ACK;
                        if (!wb.wb_we_i) begin
                            dat_d = rdata;
                        end else if (reg_sel == REG_CTRL &&
                                     wb.wb_dat_i[CTRL_INIT_BIT]) begin
                            crc_d = INIT_C;
`ifdef WB_CRC_STATS_EN
                            count_d = '0;
`endif
                        end else if (reg_sel == REG_RAW) begin
                            crc_d = wb.wb_dat_i[CRC_W-1:0];
                        end
                    end
                end
            end
            ST_PROC: begin
                crc_d = crc_step;
                rem_d = rem_next;
`ifdef WB_CRC_STATS_EN
                count_d = count_q + 32'd1;
`endif
                if (rem_next == 4'd0) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT_C;
            dbuf_q  <= '0;
            rem_q   <= '0;
            dat_q   <= '0;
`ifdef WB_CRC_STATS_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            dbuf_q  <= dbuf_d;
            rem_q   <= rem_d;
            dat_q   <= dat_d;
`ifdef WB_CRC_STATS_EN
            count_q <= count_d;
`endif
        end
    end

    assign wb.wb_ack_o = (state_q == ST_ACK);
    assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_crc_engine.sv
// tb_wb_crc_engine: directed vectors for the CRC-32 and CRC-16/CCITT-FALSE
// builds of wb_crc_engine, plus sparse-lane, seed, zero-sel and reset cases.
module tb_wb_crc_engine;
    import wb_crc_pkg::*;

`ifdef WB_CRC_STATS_EN
    localparam logic [31:0] STATS = 32'd1;
`else
    localparam logic [31:0] STATS = 32'd0;
`endif
    localparam int TMO = 20;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    wb_crc_engine_if #(.AW(32)) bus ();
    wb_crc_engine_if #(.AW(32)) bus16 ();

    wb_crc_engine u_dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb       (bus.slave)
    );

    wb_crc_engine #(
        .CRC_W       (16),
        .POLY        (32'h00001021),
        .INIT        (32'h0000FFFF),
        .XOR_OUT     (32'h00000000),
        .REFLECT_IN  (1'b0),
        .REFLECT_OUT (1'b0),
        .AW          (32)
    ) u_d16 (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb       (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          d16;
        logic        we;
        logic [2:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          rchk;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Reflected (right-shifting) CRC-32 model; the engine's RAW register
    // holds the bit reverse of this state.
    function automatic logic [31:0] ref_bytes(input logic [31:0] r0,
                                              input logic [31:0] d,
                                              input logic [3:0]  s);
        logic [31:0] r;
        r = r0;
        for (int l = 0; l < 4; l++) begin
            if (s[l]) begin
                r = r ^ {24'h0, d[l*8 +: 8]};
                for (int k = 0; k < 8; k++)
                    r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.wb_cyc_i   = 1'b0;
        bus.wb_stb_i   = 1'b0;
        bus.wb_we_i    = 1'b0;
        bus.wb_sel_i   = 4'h0;
        bus.wb_adr_i   = '0;
        bus.wb_dat_i   = '0;
        bus.wb_cti_i   = 3'b000;
        bus16.wb_cyc_i = 1'b0;
        bus16.wb_stb_i = 1'b0;
        bus16.wb_we_i  = 1'b0;
        bus16.wb_sel_i = 4'h0;
        bus16.wb_adr_i = '0;
        bus16.wb_dat_i = '0;
        bus16.wb_cti_i = 3'b000;
    endtask

    task automatic xfer(input bit d16, input logic we, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int lat);
        logic got;
        @(negedge clk);
        if (d16) begin
            bus16.wb_adr_i = {27'h0, a, 2'b00};
            bus16.wb_dat_i = d;
            bus16.wb_sel_i = s;
            bus16.wb_we_i  = we;
            bus16.wb_cti_i = 3'b111;
            bus16.wb_cyc_i = 1'b1;
            bus16.wb_stb_i = 1'b1;
        end else begin
            bus.wb_adr_i = {27'h0, a, 2'b00};
            bus.wb_dat_i = d;
            bus.wb_sel_i = s;
            bus.wb_we_i  = we;
            bus.wb_cti_i = 3'b111;
            bus.wb_cyc_i = 1'b1;
            bus.wb_stb_i = 1'b1;
        end
        lat = 0;
        rd  = '0;
        got = 1'b0;
        while (!got && lat < TMO) begin
            @(negedge clk);
            lat++;
            got = d16 ? bus16.wb_ack_o : bus.wb_ack_o;
            if (got) rd = d16 ? bus16.wb_dat_o : bus.wb_dat_o;
        end
        chk("ack_seen", {31'h0, got}, 32'h1);
        bus_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, x, m, raw_a;
        int          lat, acks;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        chk("rst_dat", bus.wb_dat_o, 32'h0);
        rst_n = 1'b1;

        m = ref_bytes(32'hFFFFFFFF, 32'h34333231, 4'hF);
        m = ref_bytes(m, 32'h38373635, 4'hF);
        m = ref_bytes(m, 32'h00000039, 4'h1);

        //          d16 we  adr         dat           sel   rchk exp   lat
        tv.push_back('{0, 0, REG_RAW,    32'h0,        4'hF, 1, 32'hFFFFFFFF, 1});
        tv.push_back('{0, 0, REG_COUNT,  32'h0,        4'hF, 1, 32'h0, 1});
        tv.push_back('{0, 1, REG_CTRL,   32'h1,        4'hF, 0, 32'h0, 1});
        tv.push_back('{0, 1, REG_DATA,   32'h34333231, 4'hF, 1, 32'h0, 5});
        tv.push_back('{0, 1, REG_DATA,   32'h38373635, 4'hF, 0, 32'h0, 5});
        tv.push_back('{0, 1, REG_DATA,   32'h00000039, 4'h1, 0, 32'h0, 2});
        tv.push_back('{0, 0, REG_RESULT, 32'h0,        4'hF, 1, 32'hCBF43926, 1});
        tv.push_back('{0, 0, REG_RAW,    32'h0,        4'hF, 1, rev32(m), 1});
        tv.push_back('{0, 0, REG_CTRL,   32'h0,        4'hF, 1,
                       (STATS << 16) | 32'h320, 1});
        tv.push_back('{0, 0, REG_COUNT,  32'h0,        4'hF, 1, STATS * 9, 1});
        tv.push_back('{0, 0, REG_DATA,   32'h0,        4'hF, 1, 32'h0, 1});
        tv.push_back('{0, 1, 3'd6,       32'hFFFFFFFF, 4'hF, 0, 32'h0, 1});
        tv.push_back('{0, 0, 3'd7,       32'h0,        4'hF, 1, 32'h0, 1});
        tv.push_back('{0, 1, REG_DATA,   32'h12345678, 4'h0, 0, 32'h0, 1});
        tv.push_back('{0, 0, REG_RAW,    32'h0,        4'hF, 1, rev32(m), 1});
        tv.push_back('{0, 0, REG_COUNT,  32'h0,        4'hF, 1, STATS * 9, 1});
        tv.push_back('{1, 1, REG_DATA,   32'h34333231, 4'hF, 0, 32'h0, 5});
        tv.push_back('{1, 1, REG_DATA,   32'h38373635, 4'hF, 0, 32'h0, 5});
        tv.push_back('{1, 1, REG_DATA,   32'h00000039, 4'h1, 0, 32'h0, 2});
        tv.push_back('{1, 0, REG_RESULT, 32'h0,        4'hF, 1, 32'h000029B1, 1});
        tv.push_back('{1, 0, REG_RAW,    32'h0,        4'hF, 1, 32'h000029B1, 1});
        tv.push_back('{1, 0, REG_CTRL,   32'h0,        4'hF, 1,
                       (STATS << 16) | 32'h10, 1});

        for (int i = 0; i < tv.size(); i++) begin
            xfer(tv[i].d16, tv[i].we, tv[i].adr, tv[i].dat, tv[i].sel, rd, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tv[i].lat));
            if (tv[i].rchk) chk($sformatf("v%0d_rd", i), rd, tv[i].exp);
        end

        // Sparse lanes 1 and 3 must match a dense two-byte write.
        m = ref_bytes(32'hFFFFFFFF, 32'h00003931, 4'h3);
        xfer(0, 1, REG_CTRL, 32'h1, 4'hF, rd, lat);
        xfer(0, 1, REG_DATA, 32'h39AA31BB, 4'b1010, rd, lat);
        chk("sparse_lat", 32'(lat), 32'd3);
        xfer(0, 0, REG_RAW, 32'h0, 4'hF, raw_a, lat);
        chk("sparse_raw", raw_a, rev32(m));
        xfer(0, 0, REG_COUNT, 32'h0, 4'hF, rd, lat);
        chk("sparse_cnt", rd, STATS * 2);
        xfer(0, 1, REG_CTRL, 32'h1, 4'hF, rd, lat);
        xfer(0, 1, REG_DATA, 32'h00003931, 4'b0011, rd, lat);
        xfer(0, 0, REG_RAW, 32'h0, 4'hF, rd, lat);
        chk("dense_raw", rd, raw_a);

        // Seed / resume across a CTRL init.
        m = ref_bytes(32'hFFFFFFFF, 32'h34333231, 4'hF);
        m = ref_bytes(m, 32'h38373635, 4'hF);
        xfer(0, 1, REG_CTRL, 32'h1, 4'hF, rd, lat);
        xfer(0, 1, REG_DATA, 32'h34333231, 4'hF, rd, lat);
        xfer(0, 1, REG_DATA, 32'h38373635, 4'hF, rd, lat);
        xfer(0, 0, REG_RAW, 32'h0, 4'hF, x, lat);
        chk("seed_x", x, rev32(m));
        xfer(0, 1, REG_CTRL, 32'h1, 4'hF, rd, lat);
        xfer(0, 1, REG_RAW, x, 4'hF, rd, lat);
        xfer(0, 1, REG_DATA, 32'h00000039, 4'h1, rd, lat);
        xfer(0, 0, REG_RESULT, 32'h0, 4'hF, rd, lat);
        chk("seed_result", rd, 32'hCBF43926);

        // Reset while the second byte of a full-word write is in flight.
        @(negedge clk);
        bus.wb_adr_i = {27'h0, REG_DATA, 2'b00};
        bus.wb_dat_i = 32'h34333231;
        bus.wb_sel_i = 4'hF;
        bus.wb_we_i  = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus_idle();
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.wb_ack_o) acks++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.wb_ack_o) acks++;
        end
        chk("rst_noack", 32'(acks), 32'd0);
        xfer(0, 0, REG_RAW, 32'h0, 4'hF, rd, lat);
        chk("rst_raw", rd, 32'hFFFFFFFF);
        xfer(0, 0, REG_COUNT, 32'h0, 4'hF, rd, lat);
        chk("rst_cnt", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
